guess_controller: RTL and testbench
===================================

// Module: guess_controller
// PURPOSE
//   Sequences the hangman game datapath. Accepts key codes from the input front-end, fetches a
//   word mask from the word ROM on new game, drives single-cycle load/load_x pulses into
//   game_handler, filters repeated letters and waits for the handler to settle before the next key.
//   Sits between the keyboard/switch decoder and game_handler; owns the mask fed to game_handler.
// PARAMETERS
//   SETTLE_CYCLES  2   cycles waited after every load pulse before game_state is sampled (>=1)
//   NUM_WORDS      16  words in the word ROM; rom_addr wraps at NUM_WORDS-1
//   ADDR_W         4   width of rom_addr (2**ADDR_W >= NUM_WORDS)
// PORTS
//   clk           in   1       system clock, all state on rising edge
//   reset         in   1       asynchronous, active-low reset
//   key_valid     in   1       key_code valid
//   key_code      in   5       0-25 = letter a-z, 26 = new game, 27-31 = unused
//   key_ready     out  1       controller can take a key this cycle
//   game_state    in   2       from game_handler: 0 START, 1 INGAME, 2 WIN, 3 LOST
//   rom_req       out  1       word fetch request, held until rom_ack
//   rom_addr      out  ADDR_W  word index, stable while rom_req high
//   rom_ack       in   1       rom_mask valid; sampled in the cycle rom_ack=1
//   rom_mask      in   26      letter mask of the fetched word
//   load          out  1       one-cycle load strobe to game_handler
//   load_x        out  5       code presented with load; holds last value otherwise
//   mask          out  26      registered word mask to game_handler
//   used_letters  out  26      letters already guessed this game
//   repeat_guess  out  1       one-cycle pulse: accepted letter was already used
//   busy          out  1       high in FETCH, ARM, ISSUE, SETTLE
// BEHAVIOUR
//   Reset (asynchronous, reset=0): state IDLE; load, rom_req, repeat_guess, busy = 0; load_x, mask,
//     used_letters, rom_addr, settle counter = 0. Mid-fetch reset drops rom_req immediately.
//   Handshake: key taken when key_valid & key_ready. key_ready=1 only in IDLE, ACCEPT, DONE.
//     Codes 27-31 are consumed and ignored in every state.
//   States:
//   IDLE   : code 26 -> FETCH; letters ignored.
//   FETCH  : rom_req=1 with rom_addr. On rom_ack: mask<=rom_mask, used_letters<=0,
//            rom_addr<=rom_addr+1 (NUM_WORDS-1 wraps to 0) -> ARM. No timeout.
//   ARM    : load=1, load_x=26 for exactly one cycle -> SETTLE.
//   ACCEPT : code 26 -> FETCH (restart, no load issued). Letter L with used_letters[L]=1 ->
//            repeat_guess=1 next cycle, stay ACCEPT, no load. Unused L -> used_letters[L]<=1,
//            load_x<=L -> ISSUE.
//   ISSUE  : load=1 for exactly one cycle -> SETTLE.
//   SETTLE : count SETTLE_CYCLES cycles, then sample game_state: 2 or 3 -> DONE; 1 -> ACCEPT;
//            0 -> ACCEPT after ARM (handler start pending is tolerated), else IDLE.
//   DONE   : code 26 -> FETCH; letters consumed, ignored, no repeat_guess.
//   Latency: key accepted in cycle N -> load=1 in cycle N+1; key_ready returns in cycle
//     N+2+SETTLE_CYCLES at earliest. Start: rom_ack in cycle M -> load (x=26) in cycle M+1.
//   load is never high two consecutive cycles; load_x is stable in every cycle load=1.
//   repeat_guess and load are mutually exclusive.
//   mask changes only on rom_ack; used_letters clears only on rom_ack or reset.
// TESTING
//   Reset then key 26, rom_ack after 3 cycles with rom_mask=26'h0000007 -> rom_req 3 cycles,
//     mask=26'h7, one load with load_x=26, rom_addr=1.
//   In ACCEPT key 0 (a) -> load=1,load_x=0 next cycle, used_letters=26'h1, key_ready low
//     SETTLE_CYCLES+1 cycles; key 0 again -> repeat_guess pulse, no load.
//   Five wrong letters with game_state forced to 3 after fifth settle -> DONE; key 4 ignored
//     (no load, no repeat_guess); key 26 -> FETCH.
//   rom_addr at NUM_WORDS-1, new game -> rom_addr wraps to 0.
//   Key 26 in ACCEPT with used_letters=26'h3 -> FETCH, used_letters=0 on rom_ack, no letter load.
//   Assert reset during FETCH with rom_req high -> rom_req=0 immediately, state IDLE, key 5 ignored.

Source files
------------

// File: rtl/guess_controller.sv
// Hangman sequencer: fetches word masks, issues load pulses to game_handler, filters repeated letters.
// Latency: key in cycle N -> load in N+1, key_ready back in N+2+SETTLE_CYCLES; rom_ack in M -> load in M+1.
// Backpressure: key_ready low in FETCH/ARM/ISSUE/SETTLE; rom_req held until rom_ack, no timeout.
module guess_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_WORDS     = 16,
  parameter int ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [4:0]        key_code,
  output logic              key_ready,
  input  logic [1:0]        game_state,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [25:0]       rom_mask,
  output logic              load,
  output logic [4:0]        load_x,
  output logic [25:0]       mask,
  output logic [25:0]       used_letters,
  output logic              repeat_guess,
  output logic              busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [4:0] NEW_GAME = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARM, S_ACCEPT, S_ISSUE, S_SETTLE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  settle_cnt;
  logic              after_arm;      // last load was the start strobe, not a letter
  logic              key_take;
  logic              is_new;
  logic              is_letter;
  logic              letter_used;
  logic              settle_last;
  logic              accept_letter;
  logic              hit_repeat;

  assign key_ready   = (state == S_IDLE) || (state == S_ACCEPT) || (state == S_DONE);
  assign key_take    = key_valid & key_ready;
  assign is_new      = (key_code == NEW_GAME);
  assign is_letter   = (key_code < NEW_GAME);
  assign letter_used = is_letter && used_letters[key_code];
  assign settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    state_nxt     = state;
    rom_req       = 1'b0;
    load          = 1'b0;
    busy          = 1'b0;
    accept_letter = 1'b0;
    hit_repeat    = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_take && is_new) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rom_req = 1'b1;
        busy    = 1'b1;
        if (rom_ack) state_nxt = S_ARM;
      end
      S_ARM: begin
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_ACCEPT: begin
        if (key_take) begin
          if (is_new) begin
            state_nxt = S_FETCH;
          end else if (letter_used) begin
            hit_repeat = 1'b1;
          end else if (is_letter) begin
            accept_letter = 1'b1;
            state_nxt     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_last) begin
          case (game_state)
            2'd2, 2'd3: state_nxt = S_DONE;
            2'd1:       state_nxt = S_ACCEPT;
            default:    state_nxt = after_arm ? S_ACCEPT : S_IDLE;
          endcase
        end
      end
      S_DONE: begin
        if (key_take && is_new) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word mask, guessed-letter set, ROM address, load code and settle timing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask         <= '0;
      used_letters <= '0;
      rom_addr     <= '0;
      load_x       <= '0;
      repeat_guess <= 1'b0;
      settle_cnt   <= '0;
      after_arm    <= 1'b0;
    end else begin
      repeat_guess <= hit_repeat;
      if (state == S_FETCH && rom_ack) begin
        mask         <= rom_mask;
        used_letters <= '0;
        load_x       <= NEW_GAME;
        rom_addr     <= (rom_addr == ADDR_W'(NUM_WORDS - 1)) ? '0 : rom_addr + 1'b1;
      end
      if (accept_letter) begin
        used_letters[key_code] <= 1'b1;
        load_x                 <= key_code;
      end
      settle_cnt <= (state == S_SETTLE && !settle_last) ? settle_cnt + 1'b1 : '0;
      if (state == S_ARM)        after_arm <= 1'b1;
      else if (state == S_ISSUE) after_arm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_guess_controller.sv
// Testbench for guess_controller: directed tables, hand sequences and randomized games.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
// ROM and game_handler are emulated by the stimulus process.
module tb_guess_controller;
  localparam int S  = 2;
  localparam int NW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid;
  logic [4:0]    key_code;
  logic          key_ready;
  logic [1:0]    game_state;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [25:0]   rom_mask;
  logic          load;
  logic [4:0]    load_x;
  logic [25:0]   mask;
  logic [25:0]   used_letters;
  logic          repeat_guess;
  logic          busy;

  guess_controller #(.SETTLE_CYCLES(S), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .game_state(game_state), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_mask(rom_mask), .load(load),
    .load_x(load_x), .mask(mask), .used_letters(used_letters),
    .repeat_guess(repeat_guess), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  int viol = 0;
  int exp_loads = 0;
  logic prev_load = 1'b0;
  logic [25:0] used_m = '0;   // reference set of guessed letters
  int addr_m = 0;             // reference word index

  // Protocol monitor: counts load pulses, flags back-to-back loads and load/repeat overlap
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      if (prev_load === 1'b1) viol++;
      if (repeat_guess === 1'b1) viol++;
    end
    prev_load = load;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for key_ready (bounded) and present one key for one cycle
  task automatic send_key(input logic [4:0] c);
    int n = 0;
    while (key_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("key_ready_timeout", {31'b0, key_ready}, 32'd1);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  // Emulate the word ROM; called in the first FETCH cycle, acks in the d-th cycle
  task automatic fetch(input logic [25:0] m, input int d);
    int req = 0;
    for (int c = 1; c <= d; c++) begin
      if (rom_req === 1'b1) req++;
      if (c == d) begin rom_ack = 1'b1; rom_mask = m; end
      tick();
    end
    rom_ack = 1'b0;
    addr_m  = (addr_m + 1) % NW;
    used_m  = '0;
    exp_loads++;
    chk("rom_req_cycles", req, d);
    chk("arm_load", {31'b0, load}, 32'd1);
    chk("arm_load_x", {27'b0, load_x}, 32'd26);
    chk("fetch_mask", {6'b0, mask}, {6'b0, m});
    chk("fetch_used_clear", {6'b0, used_letters}, 32'd0);
    chk("rom_addr", {28'b0, rom_addr}, addr_m);
  endtask

  // Send a key in ACCEPT and compare against the guessed-letter set model
  task automatic letter(input logic [4:0] c);
    bit is_l   = (c < 5'd26);
    bit exp_rp = is_l && used_m[c];
    bit exp_ld = is_l && !exp_rp;
    send_key(c);
    chk("letter_load", {31'b0, load}, {31'b0, exp_ld});
    if (exp_ld) chk("letter_load_x", {27'b0, load_x}, {27'b0, c});
    chk("letter_repeat", {31'b0, repeat_guess}, {31'b0, exp_rp});
    if (exp_ld) begin used_m[c] = 1'b1; exp_loads++; end
    chk("letter_used", {6'b0, used_letters}, {6'b0, used_m});
  endtask

  typedef struct {
    logic [4:0]  code;
    bit          ld;
    bit          rp;
    logic [25:0] used;
    int          low;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    logic [25:0] used_before;
    logic [4:0] rc;

    tbl[0] = '{5'd0,  1'b1, 1'b0, 26'h0000001, S + 1};
    tbl[1] = '{5'd0,  1'b0, 1'b1, 26'h0000001, 0};
    tbl[2] = '{5'd28, 1'b0, 1'b0, 26'h0000001, 0};
    tbl[3] = '{5'd2,  1'b1, 1'b0, 26'h0000005, S + 1};
    tbl[4] = '{5'd2,  1'b0, 1'b1, 26'h0000005, 0};
    tbl[5] = '{5'd25, 1'b1, 1'b0, 26'h2000005, S + 1};
    tbl[6] = '{5'd31, 1'b0, 1'b0, 26'h2000005, 0};

    reset = 1'b0; key_valid = 1'b0; key_code = '0;
    rom_ack = 1'b0; rom_mask = '0; game_state = 2'd1;
    tick(); tick();
    chk("rst_load", {31'b0, load}, 32'd0);
    chk("rst_rom_req", {31'b0, rom_req}, 32'd0);
    chk("rst_repeat", {31'b0, repeat_guess}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_load_x", {27'b0, load_x}, 32'd0);
    chk("rst_mask", {6'b0, mask}, 32'd0);
    chk("rst_used", {6'b0, used_letters}, 32'd0);
    chk("rst_rom_addr", {28'b0, rom_addr}, 32'd0);
    reset = 1'b1;
    tick();

    // Letters in IDLE are ignored
    send_key(5'd3);
    chk("idle_letter_load", {31'b0, load}, 32'd0);
    chk("idle_letter_busy", {31'b0, busy}, 32'd0);

    // New game; handler still reports START after the start strobe
    game_state = 2'd0;
    send_key(5'd26);
    chk("fetch_busy", {31'b0, busy}, 32'd1);
    fetch(26'h0000007, 3);
    for (int i = 0; i < S + 1; i++) tick();
    chk("arm_start_accept", {31'b0, key_ready}, 32'd1);
    game_state = 2'd1;

    // Table: letters, repeats and unused codes in ACCEPT
    for (int i = 0; i < 7; i++) begin
      send_key(tbl[i].code);
      chk("tbl_load", {31'b0, load}, {31'b0, tbl[i].ld});
      if (tbl[i].ld) chk("tbl_load_x", {27'b0, load_x}, {27'b0, tbl[i].code});
      chk("tbl_repeat", {31'b0, repeat_guess}, {31'b0, tbl[i].rp});
      chk("tbl_used", {6'b0, used_letters}, {6'b0, tbl[i].used});
      n = 0;
      while (key_ready !== 1'b1 && n < 50) begin n++; tick(); end
      chk("tbl_ready_low", n, tbl[i].low);
      if (tbl[i].ld) exp_loads++;
      used_m = tbl[i].used;
    end

    // Five wrong letters, handler reports LOST after the fifth
    for (int i = 10; i < 14; i++) letter(5'(i));
    letter(5'd14);
    game_state = 2'd3;
    n = 0;
    while (key_ready !== 1'b1 && n < 50) begin n++; tick(); end
    chk("done_not_busy", {31'b0, busy}, 32'd0);
    used_before = used_letters;
    send_key(5'd4);
    chk("done_key_load", {31'b0, load}, 32'd0);
    chk("done_key_repeat", {31'b0, repeat_guess}, 32'd0);
    chk("done_key_used", {6'b0, used_letters}, {6'b0, used_before});
    game_state = 2'd1;
    send_key(5'd26);
    chk("done_new_rom_req", {31'b0, rom_req}, 32'd1);
    fetch(26'h0155AA1, 2);

    // Handler drops back to START after a letter -> IDLE, letters ignored
    game_state = 2'd0;
    letter(5'd7);
    send_key(5'd8);
    chk("idle_again_load", {31'b0, load}, 32'd0);
    chk("idle_again_used", {6'b0, used_letters}, {6'b0, used_m});
    game_state = 2'd1;
    send_key(5'd26);
    fetch(26'h3000000, 1);

    // New game from ACCEPT with letters already used
    letter(5'd0);
    letter(5'd1);
    send_key(5'd26);
    chk("restart_rom_req", {31'b0, rom_req}, 32'd1);
    chk("restart_no_load", {31'b0, load}, 32'd0);
    chk("restart_used_held", {6'b0, used_letters}, 32'd3);
    fetch(26'h00000F0, 1);

    // Randomized games against the guessed-set model
    for (int g = 0; g < 20; g++) begin
      int nk = $urandom_range(3, 12);
      for (int k = 0; k < nk; k++) begin
        if ($urandom_range(0, 4) == 0) rc = 5'($urandom_range(27, 31));
        else                           rc = 5'($urandom_range(0, 11));
        letter(rc);
      end
      if ($urandom_range(0, 2) == 0) game_state = 2'd2;
      send_key(5'd26);
      game_state = 2'd1;
      fetch(26'($urandom), $urandom_range(1, 4));
    end

    // Word index wraps after the last ROM entry
    for (int i = 0; i < NW && rom_addr !== AW'(NW - 1); i++) begin
      send_key(5'd26);
      fetch(26'($urandom), 1);
    end
    send_key(5'd26);
    fetch(26'h0000ABC, 1);
    chk("rom_addr_wrap", {28'b0, rom_addr}, 32'd0);

    // Reset while fetching
    send_key(5'd26);
    chk("pre_reset_rom_req", {31'b0, rom_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("reset_drops_rom_req", {31'b0, rom_req}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    addr_m = 0;
    used_m = '0;
    tick();
    send_key(5'd5);
    chk("post_reset_load", {31'b0, load}, 32'd0);
    chk("post_reset_ready", {31'b0, key_ready}, 32'd1);
    chk("post_reset_addr", {28'b0, rom_addr}, 32'd0);
    chk("post_reset_mask", {6'b0, mask}, 32'd0);

    tick();
    chk("load_pulse_count", load_cnt, exp_loads);
    chk("protocol_violations", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
